pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter PWM_WIDTH, default 4: width of the measured duty value.
REQ-002 SHALL have parameter DIV_WIDTH, default 2: the sample tick fires once every 2^DIV_WIDTH clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pwm_in, input, 1 bit: asynchronous PWM waveform to be measured.
REQ-006 SHALL have port duty, output, PWM_WIDTH bits: high-time of the last complete period, in ticks.
REQ-007 SHALL have port period, output, PWM_WIDTH+1 bits: length of the last complete period, in ticks.
REQ-008 SHALL have port valid, output, 1 bit: duty/period hold a measurement not yet consumed.
REQ-009 SHALL have port ready, input, 1 bit: the consumer accepts the measurement when valid && ready.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag; a measurement was dropped while valid was high.

Function
REQ-011 SHALL pass pwm_in through a 2-flop synchronizer, then a third flop for edge detection; a rise is detected when sync=1 and prev=0.
REQ-012 SHALL generate an internal tick from a free-running DIV_WIDTH-bit counter; the tick is high for one clk when the counter equals all-ones.
REQ-013 SHALL sample the synchronized level only on tick cycles; high and period counters advance only on ticks.
REQ-014 SHALL implement the states IDLE, HIGH and LOW.
REQ-015 IDLE: waits for a rise sampled on a tick, then clears both counters to 1 and moves to HIGH.
REQ-016 HIGH: each tick with level 1 increments the high and period counters; the first tick with level 0 increments period only and moves to LOW.
REQ-017 LOW: each tick with level 0 increments period; a tick with level 1 completes the measurement and restarts the counters at 1 in HIGH.
REQ-018 On completion, duty SHALL load the high count and period SHALL load the period count, and valid SHALL rise on the next clk.
REQ-019 The measurement latency SHALL be exactly 1 clk from the completing tick to valid=1.
REQ-020 Handshake: valid stays high, with duty and period stable, until a cycle with ready=1; valid clears on the following edge.
REQ-021 Simultaneous completion and valid&&ready in the same cycle: the new result loads, valid stays 1, and overrun is not set.
REQ-022 Completion while valid=1 and ready=0: the new result is discarded, the old result is kept, and overrun is set.
REQ-023 Arithmetic: the high counter saturates at 2^PWM_WIDTH-1 and the period counter saturates at 2^(PWM_WIDTH+1)-1; neither wraps.
REQ-024 With saturation, 100% duty from a matching generator reads duty=2^PWM_WIDTH-1 and period=2^PWM_WIDTH.
REQ-025 Glitches shorter than one tick between samples SHALL be invisible; only tick-sampled levels count.

Reset
REQ-026 While reset_n=0, the block SHALL be in IDLE with duty=0, period=0, valid=0, overrun=0, all counters 0 and synchronizer flops 0.
REQ-027 Reset asserted mid-measurement SHALL abort the measurement with no completion produced.
REQ-028 After reset_n deasserts, the first measurement SHALL start at the next detected rise; a level already high at release does not count as a rise.
REQ-029 overrun SHALL clear only on reset.

Configuration
REQ-030 Macro PWM_CAPTURE_TIMEOUT_EN, when defined: if the period counter saturates in HIGH or LOW, the block SHALL emit a result and return to IDLE.
REQ-031 The timeout result is duty=all-ones with period=all-ones when stuck high, or duty=0 with period=all-ones when stuck low, with valid and overrun rules unchanged.
REQ-032 Macro undefined: counters stay saturated, no result is emitted, and the block waits indefinitely for the next edge.

Verification
REQ-033 Input high for 5 ticks, low for 11 ticks, repeating, with ready=1 -> valid pulses with duty=5 and period=16, one clk after each second rise.
REQ-034 Same stimulus with ready=0 for 3 periods -> first result held (5/16), overrun=1, valid constant 1.
REQ-035 Completion in the same cycle as valid&&ready with input 8/16 -> new result loaded, valid stays 1, overrun=0.
REQ-036 Input held low for 40 ticks after one rise, with PWM_CAPTURE_TIMEOUT_EN defined -> duty=0, period=31, then IDLE.
REQ-037 Same input without PWM_CAPTURE_TIMEOUT_EN -> no valid.
REQ-038 reset_n pulsed low mid-HIGH -> all outputs 0 immediately; the next result equals the first full period after the following rise.
REQ-039 A 1-clk high glitch between ticks during LOW -> measurement unaffected (period still 16).

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input.
//
// pwm_in is synchronized, then sampled once per divided tick (every
// 2^DIV_WIDTH clk cycles). A three-state FSM (IDLE/HIGH/LOW) counts
// tick-sampled high time and period. A finished period is presented on
// duty/period through a valid/ready output register.
//
// Optional feature, guarded by macro PWM_CAPTURE_TIMEOUT_EN:
//   when defined, a period counter that reaches all-ones in HIGH or LOW
//   emits a timeout result and returns the FSM to IDLE.
//   When undefined, the counters simply stay saturated until the next edge.
//
// Handshake (valid/ready): valid rises one clk after a completing tick
// and then holds duty/period stable. The consumer takes the result in
// any cycle with valid && ready, and valid drops on the following edge
// unless a new result completes in that same cycle, in which case the
// new result loads and valid stays high. A completion while valid=1 and
// ready=0 is dropped, the held result is kept, and the sticky overrun
// flag is set. Only reset clears overrun.
module pwm_capture #(
  parameter int PWM_WIDTH = 4,
  parameter int DIV_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pwm_in,
  output logic [PWM_WIDTH-1:0] duty,
  output logic [PWM_WIDTH:0]   period,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [PWM_WIDTH-1:0] HIGH_MAX = '1;
  localparam logic [PWM_WIDTH:0]   PER_MAX  = '1;

  // Synchronizer, tick-sampled edge flop and tick divider
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  logic                 r_primed;
  logic [DIV_WIDTH-1:0] r_div;

  // Measurement FSM
  state_t               r_state;
  logic [PWM_WIDTH-1:0] r_high;
  logic [PWM_WIDTH:0]   r_per;

  // Output register
  logic [PWM_WIDTH-1:0] r_duty;
  logic [PWM_WIDTH:0]   r_period;
  logic                 r_valid;
  logic                 r_overrun;

  // Combinational helpers
  logic                 w_tick;
  logic                 w_level;
  logic                 w_rise;
  logic [PWM_WIDTH-1:0] w_high_inc;
  logic [PWM_WIDTH:0]   w_per_inc;
  logic                 w_done;
  logic [PWM_WIDTH-1:0] w_done_duty;
  logic [PWM_WIDTH:0]   w_done_per;

  // Two-flop synchronizer for the asynchronous PWM input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running divider; the tick is the cycle where it reads all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_WIDTH'(1);
    end
  end

  assign w_tick  = &r_div;
  assign w_level = r_sync2;

  // Edge flop holds the previous tick-sampled level, so anything that
  // happens between ticks is invisible. r_primed keeps a level that is
  // already high when reset releases from looking like a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev   <= 1'b0;
      r_primed <= 1'b0;
    end else if (w_tick) begin
      r_prev   <= r_sync2;
      r_primed <= 1'b1;
    end
  end

  assign w_rise = w_tick & r_sync2 & ~r_prev & r_primed;

  // Saturating increments of the high and period counters
  always_comb begin
    w_high_inc = (r_high == HIGH_MAX) ? r_high : r_high + PWM_WIDTH'(1);
    w_per_inc  = (r_per == PER_MAX) ? r_per : r_per + (PWM_WIDTH + 1)'(1);
  end

  // Decide whether this tick finishes a measurement and with what result
  always_comb begin
    w_done      = 1'b0;
    w_done_duty = '0;
    w_done_per  = '0;
    if (w_tick) begin
      case (r_state)
        S_HIGH: begin
`ifdef PWM_CAPTURE_TIMEOUT_EN
          // Stuck high: period counter reached all-ones
          if (w_level && (w_per_inc == PER_MAX)) begin
            w_done      = 1'b1;
            w_done_duty = HIGH_MAX;
            w_done_per  = PER_MAX;
          end
`endif
        end
        S_LOW: begin
          if (w_level) begin
            w_done      = 1'b1;
            w_done_duty = r_high;
            w_done_per  = r_per;
          end
`ifdef PWM_CAPTURE_TIMEOUT_EN
          // Stuck low: period counter reached all-ones
          else if (w_per_inc == PER_MAX) begin
            w_done      = 1'b1;
            w_done_duty = '0;
            w_done_per  = PER_MAX;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Measurement FSM; counters move only on ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_high  <= '0;
      r_per   <= '0;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_high  <= PWM_WIDTH'(1);
            r_per   <= (PWM_WIDTH + 1)'(1);
            r_state <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (w_done) begin
            r_state <= S_IDLE;
          end else if (w_level) begin
            r_high <= w_high_inc;
            r_per  <= w_per_inc;
          end else begin
            r_per   <= w_per_inc;
            r_state <= S_LOW;
          end
        end
        S_LOW: begin
          if (w_level) begin
            // Rise closes this period and opens the next one
            r_high  <= PWM_WIDTH'(1);
            r_per   <= (PWM_WIDTH + 1)'(1);
            r_state <= S_HIGH;
          end else if (w_done) begin
            r_state <= S_IDLE;
          end else begin
            r_per <= w_per_inc;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty    <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_done) begin
      if (!r_valid || ready) begin
        r_duty   <= w_done_duty;
        r_period <= w_done_per;
        r_valid  <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign duty        = r_duty;
  assign period      = r_period;
  assign valid       = r_valid;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture (default parameters).
// The PWM input is driven in whole-tick segments aligned to the divider
// phase that follows each reset release; accepted results are compared
// against an expected queue.
module tb_pwm_capture;

  localparam int PW   = 4;
  localparam int DW   = 2;
  localparam int TICK = 1 << DW;
  localparam int RW   = 2 * PW + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n;
  logic          pwm_in;
  logic          ready;
  logic [PW-1:0] duty;
  logic [PW:0]   period;
  logic          valid;
  logic          overrun;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  pwm_capture #(.PWM_WIDTH(PW), .DIV_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .period     (period),
    .valid      (valid),
    .ready      (ready),
    .overrun    (overrun),
    .o_dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt    = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_e;

  typedef struct {
    int hi;
    int lo;
    int exp_duty;
    int exp_period;
  } vec_t;

  vec_t vecs[8];

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic lvl, input int nticks);
    pwm_in = lvl;
    wait_clks(TICK * nticks);
  endtask

  // Low segment with a one-clk high glitch away from the sampled slot
  task automatic seg_glitch(input int nticks, input int gidx);
    for (int t = 0; t < nticks; t++) begin
      if (t == gidx) begin
        pwm_in = 1'b0;
        wait_clks(2);
        pwm_in = 1'b1;
        wait_clks(1);
        pwm_in = 1'b0;
        wait_clks(1);
      end else begin
        seg(1'b0, 1);
      end
    end
  endtask

  // Reset released one clk after an edge; returns aligned to the sample slot
  task automatic do_reset();
    reset_n = 1'b0;
    wait_clks(2);
    reset_n = 1'b1;
    wait_clks(1);
    vcnt = 0;
    exp_q.delete();
  endtask

  task automatic push_exp(input int d, input int p);
    logic [RW-1:0] e;
    e = {d[PW-1:0], p[PW:0]};
    exp_q.push_back(e);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (valid === 1'b1) vcnt++;
      if (valid === 1'b1 && ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got duty=%0d period=%0d, expected none", duty, period);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result_duty", 32'(duty), 32'(mon_e[RW-1:PW+1]));
          chk("result_period", 32'(period), 32'(mon_e[PW:0]));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{5, 11, 5, 16};
    vecs[1] = '{8, 8, 8, 16};
    vecs[2] = '{1, 1, 1, 2};
    vecs[3] = '{1, 15, 1, 16};
    vecs[4] = '{15, 1, 15, 16};
    vecs[5] = '{20, 4, 15, 24};
    vecs[6] = '{3, 27, 3, 30};
    vecs[7] = '{16, 2, 15, 18};

    pwm_in  = 1'b0;
    ready   = 1'b0;
    reset_n = 1'b0;
    wait_clks(2);

    // Reset state, including an active input while held in reset
    chk("rst_duty", 32'(duty), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    pwm_in = 1'b1;
    wait_clks(8);
    chk("rst_state", 32'(dbg_state), 0);
    chk("rst_valid_held", 32'(valid), 0);
    pwm_in = 1'b0;

    // Table-driven periods with ready=1: three results per vector
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      repeat (3) push_exp(vecs[i].exp_duty, vecs[i].exp_period);
      seg(1'b0, 2);
      repeat (3) begin
        seg(1'b1, vecs[i].hi);
        seg(1'b0, vecs[i].lo);
      end
      seg(1'b1, 1);
      seg(1'b0, 3);
      chk($sformatf("vec%0d_drain", i), 32'(exp_q.size()), 0);
      chk($sformatf("vec%0d_pulses", i), 32'(vcnt), 3);
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 0);
    end

    // ready=0 for three periods: first result held, overrun set
    do_reset();
    ready = 1'b0;
    push_exp(5, 16);
    seg(1'b0, 2);
    repeat (3) begin
      seg(1'b1, 5);
      seg(1'b0, 11);
    end
    seg(1'b1, 1);
    seg(1'b0, 3);
    chk("ovr_valid", 32'(valid), 1);
    chk("ovr_duty", 32'(duty), 5);
    chk("ovr_period", 32'(period), 16);
    chk("ovr_flag", 32'(overrun), 1);
    ready = 1'b1;
    wait_clks(1);
    ready = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", 32'(valid), 0);
    chk("ovr_sticky", 32'(overrun), 1);
    chk("ovr_drain", 32'(exp_q.size()), 0);

    // Completion in the same cycle as the consumer takes the held result
    do_reset();
    ready = 1'b0;
    push_exp(4, 16);
    push_exp(8, 16);
    fork
      begin
        seg(1'b0, 2);
        seg(1'b1, 4);
        seg(1'b0, 12);
        seg(1'b1, 8);
        seg(1'b0, 8);
        seg(1'b1, 1);
        seg(1'b0, 3);
      end
      begin
        for (int i = 0; i < 600 && valid !== 1'b1; i++) @(negedge clk);
        if (valid !== 1'b1) begin
          chk("simul_first_valid", 32'(valid), 1);
        end else begin
          // Next completion is exactly 16 ticks (64 clks) after the first
          repeat (63) @(posedge clk);
          #1 ready = 1'b1;
          @(posedge clk);
          #1 ready = 1'b0;
          @(negedge clk);
          chk("simul_valid", 32'(valid), 1);
          chk("simul_duty", 32'(duty), 8);
          chk("simul_period", 32'(period), 16);
          chk("simul_overrun", 32'(overrun), 0);
        end
      end
    join
    ready = 1'b1;
    wait_clks(1);
    ready = 1'b0;
    @(negedge clk);
    chk("simul_consumed", 32'(valid), 0);
    chk("simul_drain", 32'(exp_q.size()), 0);

    // Reset mid-HIGH, then release with the input already high
    do_reset();
    ready = 1'b0;
    seg(1'b0, 2);
    seg(1'b1, 5);
    seg(1'b0, 11);
    seg(1'b1, 3);
    chk("mid_valid", 32'(valid), 1);
    chk("mid_duty", 32'(duty), 5);
    chk("mid_state", 32'(dbg_state), 1);
    reset_n = 1'b0;
    #1;
    chk("abort_duty", 32'(duty), 0);
    chk("abort_period", 32'(period), 0);
    chk("abort_valid", 32'(valid), 0);
    chk("abort_overrun", 32'(overrun), 0);
    chk("abort_state", 32'(dbg_state), 0);
    wait_clks(2);
    reset_n = 1'b1;
    wait_clks(1);
    vcnt  = 0;
    ready = 1'b1;
    push_exp(6, 16);
    seg(1'b1, 2);
    seg(1'b0, 4);
    seg(1'b1, 6);
    seg(1'b0, 10);
    seg(1'b1, 1);
    seg(1'b0, 3);
    chk("rearm_drain", 32'(exp_q.size()), 0);
    chk("rearm_pulses", 32'(vcnt), 1);

    // One-clk glitches between ticks during LOW
    do_reset();
    ready = 1'b1;
    push_exp(5, 16);
    push_exp(5, 16);
    seg(1'b0, 2);
    repeat (2) begin
      seg(1'b1, 5);
      seg_glitch(11, 3);
    end
    seg(1'b1, 1);
    seg(1'b0, 3);
    chk("glitch_drain", 32'(exp_q.size()), 0);
    chk("glitch_pulses", 32'(vcnt), 2);

    // One rise, then low for 40 ticks
    do_reset();
    ready = 1'b1;
`ifdef PWM_CAPTURE_TIMEOUT_EN
    push_exp(0, 31);
`endif
    seg(1'b0, 2);
    seg(1'b1, 1);
    seg(1'b0, 40);
`ifdef PWM_CAPTURE_TIMEOUT_EN
    chk("timeout_drain", 32'(exp_q.size()), 0);
    chk("timeout_pulses", 32'(vcnt), 1);
    chk("timeout_state", 32'(dbg_state), 0);
`else
    chk("stuck_pulses", 32'(vcnt), 0);
    chk("stuck_valid", 32'(valid), 0);
    chk("stuck_state", 32'(dbg_state), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
